// File: rtl/step_pattern_decoder_pkg.sv
// Shared definitions for the stepper coil pattern decoder: coil patterns,
// direction / step-size encodings, fault causes and phase arithmetic.
package step_pattern_decoder_pkg;

  // Coil drive patterns {A,B,C,D} in half-step phase order, plus idle.
  localparam logic [3:0] COIL_IDLE = 4'b0000;
  localparam logic [3:0] COIL_PH0  = 4'b1000;
  localparam logic [3:0] COIL_PH1  = 4'b1010;
  localparam logic [3:0] COIL_PH2  = 4'b0010;
  localparam logic [3:0] COIL_PH3  = 4'b0110;
  localparam logic [3:0] COIL_PH4  = 4'b0100;
  localparam logic [3:0] COIL_PH5  = 4'b0101;
  localparam logic [3:0] COIL_PH6  = 4'b0001;
  localparam logic [3:0] COIL_PH7  = 4'b1001;

  // Direction of a counted move.
  localparam logic DIR_CW  = 1'b0;
  localparam logic DIR_CCW = 1'b1;

  // Size of a counted move.
  localparam logic STEP_FULL = 1'b0;
  localparam logic STEP_HALF = 1'b1;

  // Cause of the most recent fault.
  typedef enum logic [1:0] {
    FAULT_NONE    = 2'b00,
    FAULT_ILLEGAL = 2'b01,
    FAULT_SKIP    = 2'b10
  } fault_code_e;

  // Forward distance from the reference phase to a new phase, modulo 8.
  function automatic logic [2:0] phase_delta(input logic [2:0] new_ph,
                                              input logic [2:0] ref_ph);
    return new_ph - ref_ph;
  endfunction

endpackage

// File: rtl/step_pattern_decoder_coil_phase_lookup.sv
// Combinational map from a coil drive pattern to its half-step phase.
// Idle (all coils off) and illegal patterns are flagged separately.
module coil_phase_lookup
  import step_pattern_decoder_pkg::*;
(
  input  logic [3:0] coil,
  output logic [2:0] phase,
  output logic       is_idle,
  output logic       is_illegal
);

  // Decode the pattern; anything outside the nine known patterns is illegal.
  always_comb begin
    phase      = 3'd0;
    is_idle    = 1'b0;
    is_illegal = 1'b0;
    case (coil)
      COIL_PH0:  phase = 3'd0;
      COIL_PH1:  phase = 3'd1;
      COIL_PH2:  phase = 3'd2;
      COIL_PH3:  phase = 3'd3;
      COIL_PH4:  phase = 3'd4;
      COIL_PH5:  phase = 3'd5;
      COIL_PH6:  phase = 3'd6;
      COIL_PH7:  phase = 3'd7;
      COIL_IDLE: is_idle = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/step_pattern_decoder.sv
// Stepper coil pattern decoder: tracks the observed drive phase, counts
// half/full steps in either direction into a wrapping signed position and
// raises a sticky fault on illegal patterns or skipped phases.
module step_pattern_decoder
  import step_pattern_decoder_pkg::*;
#(
  parameter int POS_W = 16
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic [3:0]              coil,
  input  logic                    coil_valid,
  input  logic                    clear_fault,
  input  logic                    pos_clear,
  output logic signed [POS_W-1:0] position,
  output logic                    direction,
  output logic                    half_mode,
  output logic                    step_pulse,
  output logic                    locked,
  output logic                    fault,
  output logic [1:0]              fault_code
);

  logic [2:0]              w_phase;
  logic                    w_is_idle;
  logic                    w_is_illegal;
  logic [2:0]              w_delta;

  logic                    w_move;
  logic [2:0]              w_inc;
  logic signed [POS_W-1:0] w_inc_ext;
  logic signed [POS_W-1:0] w_next_position;
  logic                    w_next_dir;
  logic                    w_next_half;
  logic                    w_next_locked;
  logic [2:0]              w_next_ref;
  logic                    w_new_fault;
  logic [1:0]              w_new_code;
  logic                    w_next_fault;
  logic [1:0]              w_next_code;

  logic signed [POS_W-1:0] r_position;
  logic                    r_direction;
  logic                    r_half_mode;
  logic                    r_step_pulse;
  logic                    r_locked;
  logic                    r_fault;
  logic [1:0]              r_fault_code;
  logic [2:0]              r_ref_phase;

  coil_phase_lookup u_lookup (
    .coil       (coil),
    .phase      (w_phase),
    .is_idle    (w_is_idle),
    .is_illegal (w_is_illegal)
  );

  assign w_delta   = phase_delta(w_phase, r_ref_phase);
  // Step increment is a 3-bit signed value (-2..+2), sign-extended to POS_W.
  assign w_inc_ext = {{(POS_W-3){w_inc[2]}}, w_inc};

  // Classify the strobed sample and decide lock, move and fault effects.
  always_comb begin
    w_move        = 1'b0;
    w_inc         = 3'd0;
    w_next_dir    = r_direction;
    w_next_half   = r_half_mode;
    w_next_locked = r_locked;
    w_next_ref    = r_ref_phase;
    w_new_fault   = 1'b0;
    w_new_code    = FAULT_NONE;
    if (coil_valid) begin
      if (w_is_illegal) begin
        w_new_fault   = 1'b1;
        w_new_code    = FAULT_ILLEGAL;
        w_next_locked = 1'b0;
      end else if (w_is_idle) begin
        w_next_locked = 1'b0;
      end else if (!r_locked) begin
        w_next_ref    = w_phase;
        w_next_locked = 1'b1;
      end else begin
        case (w_delta)
          3'd0: begin
            w_next_ref = w_phase;
          end
          3'd1: begin
            w_next_ref  = w_phase;
            w_move      = 1'b1;
            w_inc       = 3'b001;
            w_next_dir  = DIR_CW;
            w_next_half = STEP_HALF;
          end
          3'd2: begin
            w_next_ref  = w_phase;
            w_move      = 1'b1;
            w_inc       = 3'b010;
            w_next_dir  = DIR_CW;
            w_next_half = STEP_FULL;
          end
          3'd7: begin
            w_next_ref  = w_phase;
            w_move      = 1'b1;
            w_inc       = 3'b111;
            w_next_dir  = DIR_CCW;
            w_next_half = STEP_HALF;
          end
          3'd6: begin
            w_next_ref  = w_phase;
            w_move      = 1'b1;
            w_inc       = 3'b110;
            w_next_dir  = DIR_CCW;
            w_next_half = STEP_FULL;
          end
          default: begin
            // Three to five half steps apart: the direction is ambiguous,
            // so the lock is dropped and the next legal phase re-locks.
            w_new_fault   = 1'b1;
            w_new_code    = FAULT_SKIP;
            w_next_locked = 1'b0;
          end
        endcase
      end
    end else begin
      w_move = 1'b0;
    end
  end

  // Next position: pos_clear restarts from zero but keeps a same-cycle move.
  always_comb begin
    if (pos_clear) begin
      w_next_position = w_inc_ext;
    end else begin
      w_next_position = r_position + w_inc_ext;
    end
  end

  // Sticky fault: a freshly detected fault overrides a clear request.
  always_comb begin
    if (w_new_fault) begin
      w_next_fault = 1'b1;
      w_next_code  = w_new_code;
    end else if (clear_fault) begin
      w_next_fault = 1'b0;
      w_next_code  = FAULT_NONE;
    end else begin
      w_next_fault = r_fault;
      w_next_code  = r_fault_code;
    end
  end

  // State and output registers; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (resetb) begin
      r_position   <= '0;
      r_direction  <= DIR_CW;
      r_half_mode  <= STEP_FULL;
      r_step_pulse <= 1'b0;
      r_locked     <= 1'b0;
      r_fault      <= 1'b0;
      r_fault_code <= FAULT_NONE;
      r_ref_phase  <= 3'd0;
    end else begin
      r_position   <= w_next_position;
      r_direction  <= w_next_dir;
      r_half_mode  <= w_next_half;
      r_step_pulse <= w_move;
      r_locked     <= w_next_locked;
      r_fault      <= w_next_fault;
      r_fault_code <= w_next_code;
      r_ref_phase  <= w_next_ref;
    end
  end

  assign position   = r_position;
  assign direction  = r_direction;
  assign half_mode  = r_half_mode;
  assign step_pulse = r_step_pulse;
  assign locked     = r_locked;
  assign fault      = r_fault;
  assign fault_code = r_fault_code;

endmodule

// File: tb/tb_step_pattern_decoder.sv
// Scoreboard bench for step_pattern_decoder: directed scenarios plus random
// coil traffic, checked against an integer-arithmetic reference model.
// A second instance with POS_W=4 shares the stimulus to exercise wrap-around.
module tb_step_pattern_decoder;

  logic        clk = 1'b0;
  logic        resetb = 1'b0;
  logic [3:0]  coil = 4'b0000;
  logic        coil_valid = 1'b0;
  logic        clear_fault = 1'b0;
  logic        pos_clear = 1'b0;

  logic [15:0] pos16;
  logic        dir16, half16, pulse16, lock16, fault16;
  logic [1:0]  code16;
  logic [3:0]  pos4;
  logic        dir4, half4, pulse4, lock4, fault4;
  logic [1:0]  code4;

  step_pattern_decoder #(.POS_W(16)) dut (
    .clk(clk), .resetb(resetb), .coil(coil), .coil_valid(coil_valid),
    .clear_fault(clear_fault), .pos_clear(pos_clear),
    .position(pos16), .direction(dir16), .half_mode(half16),
    .step_pulse(pulse16), .locked(lock16), .fault(fault16),
    .fault_code(code16)
  );

  step_pattern_decoder #(.POS_W(4)) dut4 (
    .clk(clk), .resetb(resetb), .coil(coil), .coil_valid(coil_valid),
    .clear_fault(clear_fault), .pos_clear(pos_clear),
    .position(pos4), .direction(dir4), .half_mode(half4),
    .step_pulse(pulse4), .locked(lock4), .fault(fault4),
    .fault_code(code4)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] pos;
    logic        dir;
    logic        half;
    logic        pulse;
    logic        locked;
    logic        fault;
    logic [1:0]  code;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;

  // Reference model state, kept as plain integers.
  int   m_pos = 0;
  int   m_ref = 0;
  bit   m_locked = 0;
  bit   m_dir = 0;
  bit   m_half = 0;
  bit   m_pulse = 0;
  bit   m_fault = 0;
  int   m_code = 0;

  logic [3:0] patterns [8] = '{4'b1000, 4'b1010, 4'b0010, 4'b0110,
                               4'b0100, 4'b0101, 4'b0001, 4'b1001};

  // Phase index of a pattern, -1 for idle, -2 for illegal.
  function automatic int phase_of(input logic [3:0] c);
    if (c == 4'b0000) return -1;
    for (int i = 0; i < 8; i++) begin
      if (patterns[i] == c) return i;
    end
    return -2;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // One clock of the reference model, following the decoder's rules.
  task automatic model_step(input bit rb, input bit v, input logic [3:0] c,
                            input bit cf, input bit pc);
    int ph, d, inc;
    bit nf;
    int ncode;
    exp_t e;
    if (rb) begin
      m_pos = 0; m_ref = 0; m_locked = 0; m_dir = 0; m_half = 0;
      m_pulse = 0; m_fault = 0; m_code = 0;
    end else begin
      inc = 0; nf = 0; ncode = 0; m_pulse = 0;
      if (v) begin
        ph = phase_of(c);
        if (ph == -2) begin
          nf = 1; ncode = 1; m_locked = 0;
        end else if (ph == -1) begin
          m_locked = 0;
        end else if (!m_locked) begin
          m_ref = ph; m_locked = 1;
        end else begin
          d = ((ph - m_ref) % 8 + 8) % 8;
          if (d >= 3 && d <= 5) begin
            nf = 1; ncode = 2; m_locked = 0;
          end else begin
            m_ref = ph;
            if (d != 0) begin
              inc = (d <= 2) ? d : d - 8;
              m_pulse = 1;
              m_dir = (inc < 0);
              m_half = (inc == 1 || inc == -1);
            end
          end
        end
      end
      m_pos = pc ? (inc & 32'hFFFF) : ((m_pos + inc) & 32'hFFFF);
      if (nf) begin
        m_fault = 1; m_code = ncode;
      end else if (cf) begin
        m_fault = 0; m_code = 0;
      end
    end
    e.pos = m_pos[15:0]; e.dir = m_dir; e.half = m_half; e.pulse = m_pulse;
    e.locked = m_locked; e.fault = m_fault; e.code = m_code[1:0];
    exp_q.push_back(e);
  endtask

  // Drive one cycle of inputs, then record the expected registered response.
  task automatic apply(input bit rb, input bit v, input logic [3:0] c,
                       input bit cf, input bit pc);
    @(negedge clk);
    resetb = rb; coil_valid = v; coil = c; clear_fault = cf; pos_clear = pc;
    @(posedge clk);
    model_step(rb, v, c, cf, pc);
  endtask

  task automatic strobe(input logic [3:0] c);
    apply(1'b0, 1'b1, c, 1'b0, 1'b0);
  endtask

  // Monitor: compare both instances against the oldest expected response.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("position",   {16'd0, pos16},  {16'd0, e.pos});
      chk("position_w4", {28'd0, pos4},  {28'd0, e.pos[3:0]});
      chk("direction",  {31'd0, dir16},  {31'd0, e.dir});
      chk("half_mode",  {31'd0, half16}, {31'd0, e.half});
      chk("step_pulse", {31'd0, pulse16}, {31'd0, e.pulse});
      chk("locked",     {31'd0, lock16}, {31'd0, e.locked});
      chk("fault",      {31'd0, fault16}, {31'd0, e.fault});
      chk("fault_code", {30'd0, code16}, {30'd0, e.code});
      chk("w4_flags",   {26'd0, dir4, half4, pulse4, lock4, fault4, code4[0]},
                        {26'd0, e.dir, e.half, e.pulse, e.locked, e.fault, e.code[0]});
    end
  end

  initial begin
    logic [3:0] c;
    int r;

    // Full-step clockwise run: lock, then four +2 moves.
    apply(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    strobe(4'b1000); strobe(4'b0010); strobe(4'b0100);
    strobe(4'b0001); strobe(4'b1000);

    // Counterclockwise half steps from a lock at 1000.
    apply(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    strobe(4'b1000); strobe(4'b1001); strobe(4'b0001); strobe(4'b0101);

    // Skipped phase, relock without count, then clear the fault.
    apply(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    strobe(4'b1000); strobe(4'b0100); strobe(4'b0010); strobe(4'b0110);
    apply(1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);

    // Illegal pattern; clear_fault loses against a same-cycle illegal sample.
    strobe(4'b1111);
    apply(1'b0, 1'b1, 4'b1110, 1'b1, 1'b0);
    apply(1'b0, 1'b1, 4'b0000, 1'b1, 1'b0);

    // Walk position to +7 then one more half step: wraps the 4-bit instance.
    apply(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    strobe(4'b1000); strobe(4'b0010); strobe(4'b0100); strobe(4'b0001);
    strobe(4'b1001); strobe(4'b1000); strobe(4'b1000);

    // pos_clear alone and together with a counted move.
    apply(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1);
    apply(1'b0, 1'b1, 4'b1010, 1'b0, 1'b1);

    // coil toggles with coil_valid low: nothing may change.
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'b0);

    // Reset with every other input asserted.
    apply(1'b1, 1'b1, 4'b0010, 1'b1, 1'b1);
    strobe(4'b0010);

    // Random traffic biased toward legal neighbouring phases.
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 65) c = patterns[(m_ref + $urandom_range(0, 7)) % 8];
      else if (r < 75) c = 4'b0000;
      else c = 4'($urandom_range(0, 15));
      apply(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), c,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0));
    end

    @(negedge clk);
    @(negedge clk);
    #1;
    chk("queue_drain", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/step_pattern_decoder.md
STEP_PATTERN_DECODER -- requirements
Module: step_pattern_decoder

Interface
REQ-001 Parameter POS_W, default 16: width of the signed position counter, in half-step units.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 resetb  input  1  reset, synchronous, active-high.
REQ-004 coil  input  4  observed coil drive pattern {A,B,C,D}.
REQ-005 coil_valid  input  1  sample strobe; coil is evaluated only in cycles where coil_valid=1.
REQ-006 clear_fault  input  1  one-cycle request to clear the sticky fault flag.
REQ-007 pos_clear  input  1  one-cycle request to zero the position counter.
REQ-008 position  output  POS_W  signed accumulated position, in half steps, two's complement.
REQ-009 direction  output  1  direction of the last counted move: 0=clockwise, 1=counterclockwise.
REQ-010 half_mode  output  1  1 if the last counted move was a half step, 0 if it was a full step.
REQ-011 step_pulse  output  1  one-cycle pulse per counted move.
REQ-012 locked  output  1  decoder holds a valid reference phase.
REQ-013 fault  output  1  sticky error flag.
REQ-014 fault_code  output  2  cause of the last fault: 01=illegal pattern, 10=skipped phase, 00=none.

Function
REQ-015 Phase map: 1000=0, 1010=1, 0010=2, 0110=3, 0100=4, 0101=5, 0001=6, 1001=7; 0000=idle; every other pattern is illegal.
REQ-016 All outputs are registered; the response to a strobed sample appears one cycle after the coil_valid cycle.
REQ-017 coil_valid=0: hold all state; step_pulse=0.
REQ-018 Idle pattern: locked<=0, no count, no fault.
REQ-019 Legal phase while unlocked: store it as the reference phase, locked<=1, no count, no step_pulse.
REQ-020 Legal phase while locked: delta=(new-ref) mod 8, computed as a 3-bit wrapping subtraction.
REQ-021 delta=0: no move, no pulse.
REQ-022 delta=1: position+1, direction=0, half_mode=1, step_pulse=1.
REQ-023 delta=2: position+2, direction=0, half_mode=0, step_pulse=1.
REQ-024 delta=7: position-1, direction=1, half_mode=1, step_pulse=1.
REQ-025 delta=6: position-2, direction=1, half_mode=0, step_pulse=1.
REQ-026 delta in {3,4,5}: fault<=1, fault_code=10, locked<=0, no count; the next legal phase re-locks.
REQ-027 Illegal pattern in any state: fault<=1, fault_code=01, locked<=0, no count.
REQ-028 The reference phase is updated to every accepted legal phase, including delta=0.
REQ-029 Position wraps modulo 2^POS_W with no saturation and no fault.
REQ-030 pos_clear: position<=0; when a move is counted in the same cycle, position<=delta-signed increment instead.
REQ-031 clear_fault: fault<=0, fault_code<=00; a new fault detected in the same cycle wins.
REQ-032 direction and half_mode change only on counted moves.

Reset
REQ-033 resetb=1 on a clock edge: position=0, direction=0, half_mode=0, step_pulse=0, locked=0, fault=0, fault_code=00, reference phase=0.
REQ-034 Reset takes precedence over every other input, including coil_valid asserted in the same cycle.
REQ-035 Reset mid-sequence discards the reference phase; the first legal sample after reset only locks.

Structure
REQ-036 A shared package holds the nine coil pattern constants, the direction constants (clockwise=0, counterclockwise=1), the step-size constants (full=0, half=1) and the fault_code values, so the encoder and decoder share one definition.
REQ-037 Pattern-to-phase lookup is a sub-module, coil_phase_lookup: coil in; phase[2:0], is_idle and is_illegal out; purely combinational.

Verification
REQ-038 Reset, then strobe 1000, 0010, 0100, 0001, 1000 -> locked after the first sample; four step_pulses; position=8; direction=0; half_mode=0.
REQ-039 Locked at 1000, then strobe 1001, 0001, 0101 -> position -3; direction=1; half_mode=1; no fault.
REQ-040 Locked at 1000, then strobe 0100 (delta 4) -> fault=1, fault_code=10, locked=0; then strobe 0010 -> relock with no count, fault stays 1 until clear_fault.
REQ-041 Strobe 1111 -> fault_code=01; assert clear_fault with an illegal sample in the same cycle -> fault remains 1.
REQ-042 POS_W=4, position=7, one CW half step -> position=-8, no fault.
REQ-043 Hold coil_valid=0 while coil toggles -> no output change; assert resetb together with coil_valid -> all outputs take their reset values.
